bill_change_unit: RTL and testbench



---
 rtl/bill_change_unit_pkg.sv | 7 +
 rtl/bill_change_unit_subtractor_13bit.sv | 19 +
 rtl/bill_change_unit.sv | 84 ++++++++
 tb/tb_bill_change_unit.sv | 126 ++++++++++++
 4 files changed

// File: rtl/bill_change_unit_pkg.sv
// bill_change_unit_pkg: shared widths, denomination table and FSM encoding
package bill_change_unit_pkg;
  localparam int W = 13;
  localparam int NDEN = 9;
  localparam logic [W-1:0] DEN [NDEN] = '{13'd500, 13'd200, 13'd100, 13'd50, 13'd20, 13'd10, 13'd5, 13'd2, 13'd1};
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, DISPENSE = 2'd2, FINISH = 2'd3} state_t;
endpackage

// File: rtl/bill_change_unit_subtractor_13bit.sv
// subtractor_13bit: a - b as a + ~b + 1 over a ripple of full adders; borrow = no carry out
module subtractor_13bit #(
  parameter int W = 13
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);
  logic [W:0]   c;
  logic [W-1:0] nb;
  assign c[0] = 1'b1;
  assign nb = ~b_i;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff_o[i] = a_i[i] ^ nb[i] ^ c[i];
    assign c[i+1] = (a_i[i] & nb[i]) | (c[i] & (a_i[i] ^ nb[i]));
  end
  assign borrow_o = ~c[W];
endmodule

// File: rtl/bill_change_unit.sv
// bill_change_unit: computes change = paid - bill and dispenses it as notes, greedy largest-first
module bill_change_unit
  import bill_change_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bill,
  input  logic [W-1:0] paid,
  output logic         busy,
  output logic         done,
  output logic         insufficient,
  output logic [W-1:0] change,
  output logic         note_valid,
  output logic [3:0]   note_denom,
  input  logic         note_ready
);
  state_t       state_q, state_d;
  logic [W-1:0] bill_q, bill_d, paid_q, paid_d, rem_q, rem_d, chg_q, chg_d;
  logic [3:0]   idx_q, idx_d;
  logic         ins_q, ins_d;
  logic [W-1:0] chk_diff, den_diff;
  logic         chk_borrow, den_borrow;
  subtractor_13bit #(.W(W)) u_chk (.a_i(paid_q), .b_i(bill_q), .diff_o(chk_diff), .borrow_o(chk_borrow));
  subtractor_13bit #(.W(W)) u_den (.a_i(rem_q), .b_i(DEN[idx_q]), .diff_o(den_diff), .borrow_o(den_borrow));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bill_q  <= '0;
      paid_q  <= '0;
      rem_q   <= '0;
      chg_q   <= '0;
      idx_q   <= '0;
      ins_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bill_q  <= bill_d;
      paid_q  <= paid_d;
      rem_q   <= rem_d;
      chg_q   <= chg_d;
      idx_q   <= idx_d;
      ins_q   <= ins_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    bill_d     = bill_q;
    paid_d     = paid_q;
    rem_d      = rem_q;
    chg_d      = chg_q;
    idx_d      = idx_q;
    ins_d      = ins_q;
    note_valid = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        bill_d  = bill;
        paid_d  = paid;
        ins_d   = 1'b0;
        chg_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        ins_d   = chk_borrow;
        chg_d   = chk_borrow ? '0 : chk_diff;
        rem_d   = chk_borrow ? rem_q : chk_diff;
        idx_d   = chk_borrow ? idx_q : 4'd0;
        state_d = chk_borrow ? FINISH : DISPENSE;
      end
      DISPENSE: begin
        if (rem_q == '0) state_d = FINISH;
        else if (!den_borrow) begin
          note_valid = 1'b1;
          rem_d = note_ready ? den_diff : rem_q;
        end else idx_d = (idx_q == 4'(NDEN - 1)) ? idx_q : idx_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy         = state_q != IDLE;
  assign done         = state_q == FINISH;
  assign insufficient = ins_q;
  assign change       = chg_q;
  assign note_denom   = note_valid ? idx_q : 4'd0;
endmodule

// File: tb/tb_bill_change_unit.sv
// tb_bill_change_unit: directed transactions with a queue of expected notes from a greedy model
module tb_bill_change_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, note_ready = 1'b0;
  logic [12:0] bill = '0, paid = '0;
  logic        busy, done, insufficient, note_valid;
  logic [12:0] change;
  logic [3:0]  note_denom;
  int checks = 0, errors = 0;
  int exp_q[$];
  int den [9] = '{500, 200, 100, 50, 20, 10, 5, 2, 1};

  bill_change_unit dut (
    .clk(clk), .rst(rst), .start(start), .bill(bill), .paid(paid),
    .busy(busy), .done(done), .insufficient(insufficient), .change(change),
    .note_valid(note_valid), .note_denom(note_denom), .note_ready(note_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic txn(input logic [12:0] b, input logic [12:0] p, input int stall, input int exp_lat);
    int r, lat, st;
    logic exp_ins;
    exp_ins = p < b;
    r = exp_ins ? 0 : int'(p) - int'(b);
    for (int i = 0; i < 9; i++)
      while (r >= den[i]) begin
        exp_q.push_back(i);
        r -= den[i];
      end
    r = exp_ins ? 0 : int'(p) - int'(b);
    st = stall;
    lat = 0;
    @(negedge clk);
    bill = b;
    paid = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) @(negedge clk);
      if (k > 1 && k < 4) begin
        bill = 13'($urandom);
        paid = 13'($urandom);
        start = 1'b1;
      end else start = 1'b0;
      if (note_valid) begin
        if (exp_q.size() == 0) check("extra_note", note_valid, 0);
        else if (st > 0) begin
          check("stall_denom", note_denom, exp_q[0]);
          note_ready = 1'b0;
          st--;
        end else begin
          check("note_denom", note_denom, exp_q.pop_front());
          note_ready = 1'b1;
        end
      end else note_ready = (stall > 0) ? 1'b0 : 1'($urandom);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", lat != 0, 1);
    check("busy_at_done", busy, 1);
    check("change", change, r);
    check("insufficient", insufficient, exp_ins);
    check("notes_left", exp_q.size(), 0);
    if (exp_lat > 0) check("latency", lat, exp_lat);
    exp_q.delete();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("held_change", change, r);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", note_valid, 0);
    check("rst_change", change, 0);
    check("rst_insuff", insufficient, 0);
    check("rst_denom", note_denom, 0);
    rst = 1'b0;
    @(negedge clk);
    check("fixed_plan_766", 13'd2000 - 13'd1234, 766);
    txn(13'd1234, 13'd2000, 0, 0);
    txn(13'd300, 13'd299, 0, 2);
    txn(13'd450, 13'd450, 0, 3);
    txn(13'd0, 13'd8191, 0, 0);
    txn(13'd1234, 13'd2000, 5, 0);
    txn(13'd7, 13'd100, 0, 0);
    @(negedge clk);
    bill = 13'd1234;
    paid = 13'd2000;
    start = 1'b1;
    note_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", note_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", note_valid, 0);
    check("mid_rst_change", change, 0);
    check("mid_rst_done", done, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
    end
    rst = 1'b0;
    txn(13'd1234, 13'd2000, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
